dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single-ported data memory between the ARMV4 core's load/store port and a DMA/loader requester. It sits between the core and `data_memory` in the processor top. It grants one requester per cycle, using round-robin with a bounded burst length, and muxes that requester's address, write data and write enable onto the memory. While the core is not granted it stalls on `core_gnt`.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter.
//   arb_state_e   : arbiter ownership state (idle, core owns, DMA owns)
//   owner_e       : identity of the most recent owner, used to break ties
//   ARB_MAX_BURST : default burst bound for one owner under contention
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CORE,
    ST_DMA
  } arb_state_e;

  typedef enum logic {
    OWN_CORE,
    OWN_DMA
  } owner_e;

  localparam int ARB_MAX_BURST = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the core
// load/store port and a DMA/loader requester. One requester is granted per
// cycle; ownership is round-robin with a burst bound of MAX_BURST cycles
// while the other side waits. The granted side's address, write data and
// write enable are muxed onto the memory; read data is broadcast to both.
//
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   core_req/we/addr/wdata             : core request (held until granted)
//   core_gnt, core_rdata               : core grant (combinational), read data
//   dma_req/we/addr/wdata              : DMA request (held until granted)
//   dma_gnt, dma_rdata                 : DMA grant (combinational), read data
//   mem_we, mem_addr, mem_wdata        : to data_memory
//   mem_rdata                          : from data_memory (combinational read)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // A one-cycle burst still needs a 1-bit counter that simply stays at zero.
  localparam int               CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  arb_state_e       state;
  owner_e           last;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      last  <= OWN_DMA;   // core wins the first tie after reset
    end else begin
      case (state)
        ST_IDLE: begin
          count <= '0;
          if (core_req && dma_req) begin
            state <= (last == OWN_DMA) ? ST_CORE : ST_DMA;
          end else if (core_req) begin
            state <= ST_CORE;
          end else if (dma_req) begin
            state <= ST_DMA;
          end
        end

        ST_CORE: begin
          if (!core_req) begin
            state <= dma_req ? ST_DMA : ST_IDLE;
            count <= '0;
            last  <= OWN_CORE;
          end else if ((count == CNT_MAX) && dma_req) begin
            state <= ST_DMA;
            count <= '0;
            last  <= OWN_CORE;
          end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
          end
        end

        ST_DMA: begin
          if (!dma_req) begin
            state <= core_req ? ST_CORE : ST_IDLE;
            count <= '0;
            last  <= OWN_DMA;
          end else if ((count == CNT_MAX) && core_req) begin
            state <= ST_CORE;
            count <= '0;
            last  <= OWN_DMA;
          end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Grants and the write strobe are gated by reset so a mid-burst reset
  // cannot commit a write in the cycle it is asserted.
  always_comb begin
    core_gnt  = 1'b0;
    dma_gnt   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_CORE: begin
        core_gnt  = core_req & ~reset;
        mem_we    = core_req & core_we & ~reset;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      ST_DMA: begin
        dma_gnt   = dma_req & ~reset;
        mem_we    = dma_req & dma_we & ~reset;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  assign core_rdata = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario bench for dmem_arbiter with a small behavioural
// data memory. Each scenario queues its expected per-cycle grant pattern,
// then drives the cycles and pops/compares the queue at the falling edge.
module tb_dmem_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_req, core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata;
  logic              core_gnt;
  logic              dma_req, dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic              dma_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic [DATA_W-1:0] mem [0:255];
  logic              bk_we;
  logic [7:0]        bk_addr;
  logic [DATA_W-1:0] bk_data;

  typedef struct {
    logic              cg;
    logic              dg;
    logic              we;
    logic [ADDR_W-1:0] addr;
    string             tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .core_req  (core_req),
    .core_we   (core_we),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_gnt  (core_gnt),
    .core_rdata(core_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_gnt   (dma_gnt),
    .dma_rdata (dma_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Data memory: combinational read, write at the edge ending the cycle.
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic set_in(input logic cr, input logic cwe, input logic [31:0] ca, input logic [31:0] cwd,
                        input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
    core_req = cr; core_we = cwe; core_addr = ca; core_wdata = cwd;
    dma_req  = dr; dma_we  = dwe; dma_addr  = da; dma_wdata  = dwd;
  endtask

  task automatic push(input logic cg, input logic dg, input logic we, input logic [31:0] addr,
                      input string tag);
    exp_t x;
    x.cg = cg; x.dg = dg; x.we = we; x.addr = addr; x.tag = tag;
    q.push_back(x);
  endtask

  // Leaves the bench at posedge+1 with reset low and the arbiter in IDLE.
  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bk_we = 1'b0; bk_addr = 8'h00; bk_data = '0;
    set_in(1, 0, 32'h10, 0, 1, 1, 32'h20, 32'h55);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) push(0, 0, 0, 0, "reset_hold");
    push(0, 0, 0, 0, "reset_release");
    push(1, 0, 0, 32'h10, "reset_first_gnt");
    push(0, 0, 0, 0, "reset_drop");
    for (int k = 0; k < 6; k++) begin
      if (k == 3) reset = 1'b0;
      if (k == 5) set_in(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({core_gnt, dma_gnt, mem_we} !== {e.cg, e.dg, e.we}) begin
        errors++;
        $display("FAIL %s: core_gnt/dma_gnt/mem_we=%b%b%b required %b%b%b", e.tag,
                 core_gnt, dma_gnt, mem_we, e.cg, e.dg, e.we);
      end
      if (e.cg || e.dg) begin
        checks++;
        if (mem_addr !== e.addr) begin
          errors++;
          $display("FAIL %s_addr: mem_addr=%h required %h", e.tag, mem_addr, e.addr);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single();
    do_reset();
    push(0, 0, 0, 0,     "single_c0");
    push(1, 0, 1, 32'h40, "single_core_wr");
    push(0, 0, 0, 0,     "single_c2");
    push(0, 0, 0, 0,     "single_c3");
    push(0, 1, 0, 32'h40, "single_dma_rd");
    for (int k = 0; k < 5; k++) begin
      if (k <= 1)      set_in(1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0);
      else if (k == 2) set_in(0, 0, 0, 0, 0, 0, 0, 0);
      else             set_in(0, 0, 0, 0, 1, 0, 32'h40, 0);
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({core_gnt, dma_gnt, mem_we} !== {e.cg, e.dg, e.we}) begin
        errors++;
        $display("FAIL %s: core_gnt/dma_gnt/mem_we=%b%b%b required %b%b%b", e.tag,
                 core_gnt, dma_gnt, mem_we, e.cg, e.dg, e.we);
      end
      if (e.cg || e.dg) begin
        checks++;
        if (mem_addr !== e.addr) begin
          errors++;
          $display("FAIL %s_addr: mem_addr=%h required %h", e.tag, mem_addr, e.addr);
        end
      end
      if (k == 1) begin
        checks++;
        if (mem_wdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL single_wdata: mem_wdata=%h required deadbeef", mem_wdata);
        end
      end
      if (k == 4) begin
        checks++;
        if (dma_rdata !== 32'hDEADBEEF || core_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL single_rdata: dma_rdata=%h core_rdata=%h required deadbeef",
                   dma_rdata, core_rdata);
        end
      end
      @(posedge clk); #1;
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_contention();
    do_reset();
    push(0, 0, 0, 0, "cont_c0");
    for (int k = 1; k <= 12; k++) begin
      if (((k - 1) / MAX_BURST) % 2 == 0) push(1, 0, 0, 32'h100, "cont_core");
      else                                push(0, 1, 0, 32'h200, "cont_dma");
    end
    set_in(1, 0, 32'h100, 0, 1, 0, 32'h200, 0);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({core_gnt, dma_gnt, mem_we} !== {e.cg, e.dg, e.we}) begin
        errors++;
        $display("FAIL %s cycle %0d: core_gnt/dma_gnt/mem_we=%b%b%b required %b%b%b", e.tag, k,
                 core_gnt, dma_gnt, mem_we, e.cg, e.dg, e.we);
      end
      if (e.cg || e.dg) begin
        checks++;
        if (mem_addr !== e.addr) begin
          errors++;
          $display("FAIL %s_addr cycle %0d: mem_addr=%h required %h", e.tag, k, mem_addr, e.addr);
        end
      end
      @(posedge clk); #1;
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_early_release();
    do_reset();
    push(0, 0, 0, 0,      "early_c0");
    push(1, 0, 0, 32'h104, "early_core1");
    push(1, 0, 0, 32'h104, "early_core2");
    push(0, 0, 0, 0,      "early_release");
    push(0, 1, 1, 32'h208, "early_dma4");
    push(0, 1, 1, 32'h208, "early_dma5");
    for (int k = 0; k < 6; k++) begin
      set_in(k <= 2, 0, 32'h104, 0, 1, 1, 32'h208, 32'h77);
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({core_gnt, dma_gnt, mem_we} !== {e.cg, e.dg, e.we}) begin
        errors++;
        $display("FAIL %s: core_gnt/dma_gnt/mem_we=%b%b%b required %b%b%b", e.tag,
                 core_gnt, dma_gnt, mem_we, e.cg, e.dg, e.we);
      end
      if (e.cg || e.dg) begin
        checks++;
        if (mem_addr !== e.addr) begin
          errors++;
          $display("FAIL %s_addr: mem_addr=%h required %h", e.tag, mem_addr, e.addr);
        end
      end
      @(posedge clk); #1;
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_late_arrival();
    do_reset();
    push(0, 0, 0, 0, "late_c0");
    for (int k = 1; k <= 10; k++) push(1, 0, 0, 32'h10C, "late_core");
    push(0, 1, 0, 32'h20C, "late_dma11");
    for (int k = 0; k <= 11; k++) begin
      set_in(1, 0, 32'h10C, 0, k >= 10, 0, 32'h20C, 0);
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({core_gnt, dma_gnt, mem_we} !== {e.cg, e.dg, e.we}) begin
        errors++;
        $display("FAIL %s cycle %0d: core_gnt/dma_gnt/mem_we=%b%b%b required %b%b%b", e.tag, k,
                 core_gnt, dma_gnt, mem_we, e.cg, e.dg, e.we);
      end
      if (e.cg || e.dg) begin
        checks++;
        if (mem_addr !== e.addr) begin
          errors++;
          $display("FAIL %s_addr cycle %0d: mem_addr=%h required %h", e.tag, k, mem_addr, e.addr);
        end
      end
      @(posedge clk); #1;
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    // Preload a known word so a suppressed write is observable.
    bk_we = 1'b1; bk_addr = 8'h80; bk_data = 32'hA5A5A5A5;
    do_reset();
    bk_we = 1'b0;
    push(0, 0, 0, 0,      "rmid_c0");
    push(0, 0, 0, 0,      "rmid_reset_cycle");
    push(0, 0, 0, 0,      "rmid_release");
    push(1, 0, 0, 32'h84, "rmid_core_first");
    for (int k = 0; k < 4; k++) begin
      reset = (k == 1);
      set_in(k >= 2, 0, 32'h84, 0, 1, 1, 32'h80, 32'h12345678);
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({core_gnt, dma_gnt, mem_we} !== {e.cg, e.dg, e.we}) begin
        errors++;
        $display("FAIL %s: core_gnt/dma_gnt/mem_we=%b%b%b required %b%b%b", e.tag,
                 core_gnt, dma_gnt, mem_we, e.cg, e.dg, e.we);
      end
      if (e.cg || e.dg) begin
        checks++;
        if (mem_addr !== e.addr) begin
          errors++;
          $display("FAIL %s_addr: mem_addr=%h required %h", e.tag, mem_addr, e.addr);
        end
      end
      if (k >= 2) begin
        checks++;
        if (mem[8'h80] !== 32'hA5A5A5A5) begin
          errors++;
          $display("FAIL rmid_mem_unchanged: mem[0x80]=%h required a5a5a5a5", mem[8'h80]);
        end
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_late_arrival();
    test_reset_mid();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
